load_req_gen: RTL and testbench

Sits directly downstream of the load-tiling loop-index generator: accepts one load tuple per cycle (input-feature index, row index, column start/end, target buffer) and turns it into a DRAM read request (byte address, pixel length, buffer select) for the input-buffer fill engine. It buffers tuples in a small FIFO, computes addresses in a two-stage stallable pipeline, classifies out-of-range rows as padding, and clips masked/wrapped column ranges to the feature-map width.

---
 rtl/load_req_gen_pkg.sv | 57 +++++
 rtl/load_req_gen_if.sv | 38 +++
 rtl/load_req_fifo.sv | 51 +++++
 rtl/load_req_gen.sv | 150 +++++++++++++++
 tb/tb_load_req_gen.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_req_gen_pkg.sv
// Shared types for the load request generator: widths, config record, tuple/request records.
// Also holds the pixel-length clip helper used by stage 1.
package load_req_gen_pkg;

    localparam int ADDR_W           = 32;
    localparam int IDX_W            = 16;
    localparam int FIFO_DEPTH_2POW  = 2;
    localparam int PIXEL_BYTES_2POW = 0;
    localparam int BUF_SEL_W        = 2;
    localparam int DEPTH            = 1 << FIFO_DEPTH_2POW;

    typedef struct packed {
        logic [IDX_W-1:0]  ix;
        logic [IDX_W-1:0]  iy;
        logic [ADDR_W-1:0] plane;
        logic [ADDR_W-1:0] base;
    } cfg_t;

    typedef struct packed {
        logic [IDX_W-1:0]     feat;
        logic [IDX_W-1:0]     row;
        logic [IDX_W-1:0]     col_start;
        logic [IDX_W-1:0]     col_end;
        logic [BUF_SEL_W-1:0] buf_sel;
        logic                 last;
    } tuple_t;

    typedef struct packed {
        logic                 pad;
        logic [IDX_W-1:0]     len;
        logic [ADDR_W-1:0]    pa;
        logic [ADDR_W-1:0]    pb;
        logic [IDX_W-1:0]     col_start;
        logic [BUF_SEL_W-1:0] buf_sel;
        logic                 last;
    } s1_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [IDX_W-1:0]     len;
        logic                 pad;
        logic [BUF_SEL_W-1:0] buf_sel;
        logic                 last;
    } req_t;

    // A wrapped (end < start) range runs to the right edge; any range is clipped to ix.
    function automatic logic [IDX_W-1:0] calc_len(input logic [IDX_W-1:0] ix,
                                                  input logic [IDX_W-1:0] cs,
                                                  input logic [IDX_W-1:0] ce);
        logic [IDX_W:0] avail;
        logic [IDX_W:0] raw;
        avail = (cs > ix) ? '0 : ({1'b0, ix} - {1'b0, cs} + (IDX_W+1)'(1));
        raw   = (ce >= cs) ? ({1'b0, ce} - {1'b0, cs} + (IDX_W+1)'(1)) : avail;
        return (raw > avail) ? avail[IDX_W-1:0] : raw[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/load_req_gen_if.sv
// Valid/ready buses: load tuples in from the loop-index generator, read requests out.
// master drives valid and payload, slave drives ready.
interface load_idx_if;
    import load_req_gen_pkg::*;

    logic                 idx_valid;
    logic                 idx_ready;
    logic [IDX_W-1:0]     idx_if;
    logic [IDX_W-1:0]     idx_row;
    logic [IDX_W-1:0]     idx_col_start;
    logic [IDX_W-1:0]     idx_col_end;
    logic [BUF_SEL_W-1:0] idx_buf;
    logic                 idx_last;

    modport master (output idx_valid, idx_if, idx_row, idx_col_start, idx_col_end,
                           idx_buf, idx_last,
                    input  idx_ready);
    modport slave  (input  idx_valid, idx_if, idx_row, idx_col_start, idx_col_end,
                           idx_buf, idx_last,
                    output idx_ready);
endinterface

interface load_rd_if;
    import load_req_gen_pkg::*;

    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_W-1:0]    rd_addr;
    logic [IDX_W-1:0]     rd_len;
    logic                 rd_pad;
    logic [BUF_SEL_W-1:0] rd_buf;
    logic                 rd_last;

    modport master (output rd_valid, rd_addr, rd_len, rd_pad, rd_buf, rd_last,
                    input  rd_ready);
    modport slave  (input  rd_valid, rd_addr, rd_len, rd_pad, rd_buf, rd_last,
                    output rd_ready);
endinterface

// File: rtl/load_req_fifo.sv
// Show-ahead sync FIFO with occupancy count and synchronous flush; pop data valid same cycle as !empty.
// No internal protection: caller must not push when full or pop when empty.
module load_req_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_2POW = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_dat,
    input  logic                  pop,
    output logic [WIDTH-1:0]      pop_dat,
    output logic [DEPTH_2POW:0]   count,
    output logic                  empty,
    output logic                  full
);
    localparam int DEPTH = 1 << DEPTH_2POW;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_2POW-1:0] wr_ptr;
    logic [DEPTH_2POW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + DEPTH_2POW'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_2POW'(1);
            count <= count + {{DEPTH_2POW{1'b0}}, push} - {{DEPTH_2POW{1'b0}}, pop};
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
    // Count tops out at exactly DEPTH, so the MSB alone means full.
    assign full    = count[DEPTH_2POW];

endmodule

// File: rtl/load_req_gen.sv
// Load tuple -> DRAM read request: FIFO, stage 1 (pad/len/products), output stage (address).
// Accept-to-rd_valid is 2 edges (sampled at the 3rd); rd_ready low freezes output, stage 1 and FIFO pop.
module load_req_gen
    import load_req_gen_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_load,
    input  logic [IDX_W-1:0]  cfg_ix,
    input  logic [IDX_W-1:0]  cfg_iy,
    input  logic [ADDR_W-1:0] cfg_plane,
    input  logic [ADDR_W-1:0] cfg_base,
    load_idx_if.slave         idx,
    load_rd_if.master         rd,
    output logic              busy,
    output logic              done,
    output logic [15:0]       req_count
);
    cfg_t   cfg;
    tuple_t push_dat;
    tuple_t head;
    logic   push;
    logic   pop;
    logic   fifo_empty;
    logic   fifo_full;
    logic [FIFO_DEPTH_2POW:0] fifo_count;

    s1_t    s1;
    s1_t    s1_nxt;
    logic   s1_vld;
    logic   s1_adv;

    req_t   out_q;
    req_t   out_nxt;
    logic   out_vld;
    logic   out_adv;
    logic   rd_hs;

    logic [IDX_W-1:0]  feat_m1;
    logic [IDX_W-1:0]  row_m1;
    logic [ADDR_W-1:0] offset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg <= '0;
        end else if (cfg_load) begin
            cfg <= '{ix: cfg_ix, iy: cfg_iy, plane: cfg_plane, base: cfg_base};
        end
    end

    // A tuple offered in the cfg_load cycle is refused rather than tagged with stale config.
    assign idx.idx_ready = !fifo_full && !cfg_load;
    assign push          = idx.idx_valid && idx.idx_ready;
    assign push_dat      = '{feat:      idx.idx_if,
                             row:       idx.idx_row,
                             col_start: idx.idx_col_start,
                             col_end:   idx.idx_col_end,
                             buf_sel:   idx.idx_buf,
                             last:      idx.idx_last};

    assign out_adv = !out_vld || rd.rd_ready;
    assign s1_adv  = !s1_vld || out_adv;
    assign pop     = s1_adv && !fifo_empty;
    assign rd_hs   = out_vld && rd.rd_ready;

    load_req_fifo #(
        .WIDTH      ($bits(tuple_t)),
        .DEPTH_2POW (FIFO_DEPTH_2POW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (cfg_load),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        feat_m1          = head.feat - IDX_W'(1);
        row_m1           = head.row - IDX_W'(1);
        s1_nxt           = '0;
        s1_nxt.pad       = (head.row == '0) || (head.row > cfg.iy);
        s1_nxt.len       = calc_len(cfg.ix, head.col_start, head.col_end);
        s1_nxt.pa        = ADDR_W'(feat_m1) * cfg.plane;
        s1_nxt.pb        = ADDR_W'(row_m1) * ADDR_W'(cfg.ix);
        s1_nxt.col_start = head.col_start;
        s1_nxt.buf_sel   = head.buf_sel;
        s1_nxt.last      = head.last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld <= 1'b0;
            s1     <= '0;
        end else if (cfg_load) begin
            s1_vld <= 1'b0;
        end else if (s1_adv) begin
            s1_vld <= !fifo_empty;
            if (!fifo_empty) s1 <= s1_nxt;
        end
    end

    always_comb begin
        offset          = s1.pa + s1.pb + ADDR_W'(s1.col_start) - ADDR_W'(1);
        out_nxt         = '0;
        out_nxt.addr    = s1.pad ? '0 : cfg.base + (offset << PIXEL_BYTES_2POW);
        out_nxt.len     = s1.len;
        out_nxt.pad     = s1.pad;
        out_nxt.buf_sel = s1.buf_sel;
        out_nxt.last    = s1.last;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld <= 1'b0;
            out_q   <= '0;
        end else if (cfg_load) begin
            out_vld <= 1'b0;
        end else if (out_adv) begin
            out_vld <= s1_vld;
            if (s1_vld) out_q <= out_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_count <= '0;
            done      <= 1'b0;
        end else if (cfg_load) begin
            req_count <= '0;
            done      <= 1'b0;
        end else begin
            if (rd_hs) req_count <= req_count + 16'd1;
            done <= rd_hs && out_q.last;
        end
    end

    assign rd.rd_valid = out_vld;
    assign rd.rd_addr  = out_q.addr;
    assign rd.rd_len   = out_q.len;
    assign rd.rd_pad   = out_q.pad;
    assign rd.rd_buf   = out_q.buf_sel;
    assign rd.rd_last  = out_q.last;
    assign busy        = (fifo_count != '0) || s1_vld || out_vld;

endmodule

// File: tb/tb_load_req_gen.sv
// Directed bench for load_req_gen: stimulus pushes expected requests into a queue,
// a negedge monitor pops and compares on every rd handshake.
module tb_load_req_gen;
    import load_req_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_load;
    logic [15:0] cfg_ix, cfg_iy;
    logic [31:0] cfg_plane, cfg_base;
    logic        busy, done;
    logic [15:0] req_count;

    load_idx_if idx_bus ();
    load_rd_if  rd_bus ();

    load_req_gen dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_load  (cfg_load),
        .cfg_ix    (cfg_ix),
        .cfg_iy    (cfg_iy),
        .cfg_plane (cfg_plane),
        .cfg_base  (cfg_base),
        .idx       (idx_bus),
        .rd        (rd_bus),
        .busy      (busy),
        .done      (done),
        .req_count (req_count)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    req_t sb[$];
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on handshake, check rd_* hold under stall and the done pulse.
    req_t cur, held_val, e;
    bit   held = 1'b0, exp_done = 1'b0, hs;
    always @(negedge clk) begin
        cur = '{addr: rd_bus.rd_addr, len: rd_bus.rd_len, pad: rd_bus.rd_pad,
                buf_sel: rd_bus.rd_buf, last: rd_bus.rd_last};
        if (mon_en) begin
            chk("done", done, exp_done);
            if (held) chk("rd_hold", cur, held_val);
            hs = rd_bus.rd_valid && rd_bus.rd_ready;
            if (hs) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_req: got addr 0x%0h, expected no request", cur.addr);
                end else begin
                    e = sb.pop_front();
                    chk("rd_addr", cur.addr, e.addr);
                    chk("rd_len",  cur.len,  e.len);
                    chk("rd_pad",  cur.pad,  e.pad);
                    chk("rd_buf",  cur.buf_sel, e.buf_sel);
                    chk("rd_last", cur.last, e.last);
                end
            end
            exp_done = hs && rd_bus.rd_last;
            held     = rd_bus.rd_valid && !rd_bus.rd_ready;
            held_val = cur;
        end else begin
            exp_done = 1'b0;
            held     = 1'b0;
        end
    end

    task automatic set_idx(input logic [15:0] f, r, cs, ce, input logic [1:0] b, input logic l);
        idx_bus.idx_if        = f;
        idx_bus.idx_row       = r;
        idx_bus.idx_col_start = cs;
        idx_bus.idx_col_end   = ce;
        idx_bus.idx_buf       = b;
        idx_bus.idx_last      = l;
    endtask

    task automatic do_cfg(input logic [15:0] ix, iy, input logic [31:0] plane, base);
        cfg_ix = ix; cfg_iy = iy; cfg_plane = plane; cfg_base = base;
        cfg_load = 1'b1;
        @(posedge clk); #2;
        cfg_load = 1'b0;
    endtask

    // Offers one tuple until accepted; returns 2ns after the accepting edge.
    task automatic push(input logic [15:0] f, r, cs, ce, input logic [1:0] b,
                        input logic l, input req_t exp_req);
        bit got = 1'b0;
        set_idx(f, r, cs, ce, b, l);
        idx_bus.idx_valid = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            got = idx_bus.idx_ready;
            @(posedge clk); #2;
            if (got) break;
        end
        idx_bus.idx_valid = 1'b0;
        chk("push_accept", got, 1'b1);
        if (got) sb.push_back(exp_req);
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain", ok, 1'b1);
        @(posedge clk); #2;
    endtask

    function automatic req_t stall_exp(input int i);
        return '{addr: 32'h1000_0000 + 32'(i) * 32'd64, len: 16'd64, pad: 1'b0,
                 buf_sel: 2'(i % 4), last: (i == 4)};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int acc;

    initial begin
        reset = 1'b1; cfg_load = 1'b0;
        cfg_ix = '0; cfg_iy = '0; cfg_plane = '0; cfg_base = '0;
        idx_bus.idx_valid = 1'b0;
        set_idx(0, 0, 0, 0, 0, 0);
        rd_bus.rd_ready = 1'b0;

        @(negedge clk);
        chk("rst_idx_ready", idx_bus.idx_ready, 1'b1);
        chk("rst_rd_valid",  rd_bus.rd_valid, 1'b0);
        chk("rst_rd_addr",   rd_bus.rd_addr, 32'h0);
        chk("rst_rd_len",    rd_bus.rd_len, 16'h0);
        chk("rst_rd_pad",    rd_bus.rd_pad, 1'b0);
        chk("rst_rd_buf",    rd_bus.rd_buf, 2'h0);
        chk("rst_rd_last",   rd_bus.rd_last, 1'b0);
        chk("rst_busy",      busy, 1'b0);
        chk("rst_done",      done, 1'b0);
        chk("rst_req_count", req_count, 16'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        // Main address case and latency
        do_cfg(16'd64, 16'd32, 32'd2048, 32'h1000_0000);
        rd_bus.rd_ready = 1'b1;
        mon_en = 1'b1;
        push(2, 3, 33, 64, 1, 0, '{addr: 32'h1000_08A0, len: 16'd32, pad: 1'b0, buf_sel: 2'd1, last: 1'b0});
        @(negedge clk); chk("lat_edge_t1", rd_bus.rd_valid, 1'b0);
        @(negedge clk); chk("lat_edge_t2", rd_bus.rd_valid, 1'b0);
        @(negedge clk); chk("lat_edge_t3", rd_bus.rd_valid, 1'b1);
        @(posedge clk); #2;

        // Padding rows and the last valid row
        push(1, 0,  33, 64, 2, 0, '{addr: 32'h0, len: 16'd32, pad: 1'b1, buf_sel: 2'd2, last: 1'b0});
        push(1, 33, 33, 64, 3, 0, '{addr: 32'h0, len: 16'd32, pad: 1'b1, buf_sel: 2'd3, last: 1'b0});
        push(1, 32, 1,  64, 0, 0, '{addr: 32'h1000_07C0, len: 16'd64, pad: 1'b0, buf_sel: 2'd0, last: 1'b0});
        wait_drain();

        // Narrow map: masked wrap, full width, clipped range
        do_cfg(16'd48, 16'd32, 32'd1536, 32'h2000_0000);
        push(1, 1, 33, 0,  0, 0, '{addr: 32'h2000_0020, len: 16'd16, pad: 1'b0, buf_sel: 2'd0, last: 1'b0});
        push(1, 2, 1,  48, 1, 0, '{addr: 32'h2000_0030, len: 16'd48, pad: 1'b0, buf_sel: 2'd1, last: 1'b0});
        push(1, 1, 40, 60, 2, 0, '{addr: 32'h2000_0027, len: 16'd9,  pad: 1'b0, buf_sel: 2'd2, last: 1'b0});
        wait_drain();

        // Full stall: 10 offered, 6 held, then released in order with last on the 5th
        do_cfg(16'd64, 16'd32, 32'd2048, 32'h1000_0000);
        rd_bus.rd_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 15; c++) begin
            set_idx(16'd1, 16'(acc + 1), 16'd1, 16'd64, 2'(acc % 4), acc == 4);
            idx_bus.idx_valid = (acc < 10);
            @(negedge clk);
            if (idx_bus.idx_valid && idx_bus.idx_ready) begin
                sb.push_back(stall_exp(acc));
                acc++;
            end
            @(posedge clk); #2;
        end
        chk("stall_accepted", acc, DEPTH + 2);
        chk("stall_idx_ready", idx_bus.idx_ready, 1'b0);
        chk("stall_busy", busy, 1'b1);
        rd_bus.rd_ready = 1'b1;
        for (int c = 0; c < 100 && acc < 10; c++) begin
            set_idx(16'd1, 16'(acc + 1), 16'd1, 16'd64, 2'(acc % 4), acc == 4);
            idx_bus.idx_valid = 1'b1;
            @(negedge clk);
            if (idx_bus.idx_ready) begin
                sb.push_back(stall_exp(acc));
                acc++;
            end
            @(posedge clk); #2;
        end
        idx_bus.idx_valid = 1'b0;
        chk("stall_all_accepted", acc, 10);
        wait_drain();
        chk("stall_req_count", req_count, 16'd10);

        // Reset with three tuples in flight
        rd_bus.rd_ready = 1'b0;
        push(1, 5,  1, 64, 3, 1, '{addr: 32'h1000_0100, len: 16'd64, pad: 1'b0, buf_sel: 2'd3, last: 1'b1});
        push(1, 0,  1, 64, 0, 0, '{addr: 32'h0, len: 16'd64, pad: 1'b1, buf_sel: 2'd0, last: 1'b0});
        push(1, 6,  1, 64, 1, 0, '{addr: 32'h1000_0140, len: 16'd64, pad: 1'b0, buf_sel: 2'd1, last: 1'b0});
        #1;
        chk("pre_reset_rd_valid", rd_bus.rd_valid, 1'b1);
        chk("pre_reset_rd_addr",  rd_bus.rd_addr, 32'h1000_0100);
        mon_en = 1'b0;
        sb.delete();
        reset = 1'b1;
        #1;
        chk("mid_rst_rd_valid",  rd_bus.rd_valid, 1'b0);
        chk("mid_rst_rd_addr",   rd_bus.rd_addr, 32'h0);
        chk("mid_rst_rd_len",    rd_bus.rd_len, 16'h0);
        chk("mid_rst_rd_buf",    rd_bus.rd_buf, 2'h0);
        chk("mid_rst_rd_last",   rd_bus.rd_last, 1'b0);
        chk("mid_rst_busy",      busy, 1'b0);
        chk("mid_rst_idx_ready", idx_bus.idx_ready, 1'b1);
        chk("mid_rst_req_count", req_count, 16'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        // cfg_load mid-stream
        do_cfg(16'd64, 16'd32, 32'd2048, 32'h1000_0000);
        rd_bus.rd_ready = 1'b1;
        mon_en = 1'b1;
        push(1, 1, 1, 64, 0, 0, '{addr: 32'h1000_0000, len: 16'd64, pad: 1'b0, buf_sel: 2'd0, last: 1'b0});
        wait_drain();
        chk("pre_flush_req_count", req_count, 16'd1);
        rd_bus.rd_ready = 1'b0;
        push(1, 2, 1, 64, 0, 0, '{addr: 32'h1000_0040, len: 16'd64, pad: 1'b0, buf_sel: 2'd0, last: 1'b0});
        push(1, 3, 1, 64, 0, 0, '{addr: 32'h1000_0080, len: 16'd64, pad: 1'b0, buf_sel: 2'd0, last: 1'b0});
        push(1, 4, 1, 64, 0, 0, '{addr: 32'h1000_00C0, len: 16'd64, pad: 1'b0, buf_sel: 2'd0, last: 1'b0});
        mon_en = 1'b0;
        sb.delete();
        set_idx(1, 7, 1, 64, 0, 0);
        idx_bus.idx_valid = 1'b1;
        cfg_load = 1'b1;
        #1;
        chk("cfgload_idx_ready", idx_bus.idx_ready, 1'b0);
        @(posedge clk); #2;
        cfg_load = 1'b0;
        idx_bus.idx_valid = 1'b0;
        #1;
        chk("flush_busy",      busy, 1'b0);
        chk("flush_req_count", req_count, 16'h0);
        chk("flush_rd_valid",  rd_bus.rd_valid, 1'b0);
        chk("flush_idx_ready", idx_bus.idx_ready, 1'b1);
        @(negedge clk);
        chk("flush_drop_busy", busy, 1'b0);
        @(posedge clk); #2;

        // Pipeline usable after flush; last request raises done
        rd_bus.rd_ready = 1'b1;
        mon_en = 1'b1;
        push(2, 3, 33, 64, 1, 1, '{addr: 32'h1000_08A0, len: 16'd32, pad: 1'b0, buf_sel: 2'd1, last: 1'b1});
        wait_drain();
        chk("post_flush_req_count", req_count, 16'd1);
        @(negedge clk);
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
